// File: rtl/mac_pe_seq_pkg.sv
// Shared types for the mac_pe operand sequencer.
package mac_pe_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    CAPTURE,
    RESULT
  } mac_seq_state_e;

endpackage

// File: rtl/mac_pe.sv
// Multiply-accumulate PE: clear has priority, accumulate when both operands valid.
module mac_pe #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  acc_clr_i,
  input  logic                  a_valid_i,
  input  logic                  b_valid_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] acc_o
);

  logic [DATA_WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (acc_clr_i) begin
      acc_d = '0;
    end else if (a_valid_i && b_valid_i) begin
      acc_d = acc_q + a_i * b_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mac_pe_sequencer.sv
// Streams k operand pairs from two SRAMs into a mac_pe and returns the dot product.
// Optional busy-cycle counter enabled by MAC_PE_SEQ_PERF_EN.
//
// state   | meaning
// IDLE    | waiting for start_i
// CLEAR   | clear PE accumulator, read address 0 when k>0
// STREAM  | read addresses 1..k-1, one per cycle
// CAPTURE | wait out the last valid beat, then register acc_i
// RESULT  | hold res_o until res_ready_i
module mac_pe_sequencer
  import mac_pe_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int K_MAX      = 16,
  parameter int ADDR_WIDTH = $clog2(K_MAX),
  parameter int LEN_WIDTH  = $clog2(K_MAX + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  k_len_i,
  output logic                  busy_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] a_rdata_i,
  input  logic [DATA_WIDTH-1:0] b_rdata_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic                  a_valid_o,
  output logic                  b_valid_o,
  output logic                  acc_clr_o,
  input  logic [DATA_WIDTH-1:0] acc_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i
`ifdef MAC_PE_SEQ_PERF_EN
  ,
  output logic [31:0]           perf_busy_cycles_o
`endif
);

  mac_seq_state_e        state_q, state_d;
  logic [LEN_WIDTH-1:0]  k_q, k_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  res_valid_q, res_valid_d;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  acc_clr;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    addr_d      = addr_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    rd_en       = 1'b0;
    rd_addr     = '0;
    acc_clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          k_d     = (k_len_i > LEN_WIDTH'(K_MAX)) ? LEN_WIDTH'(K_MAX) : k_len_i;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        acc_clr = 1'b1;
        rd_en   = (k_q != '0);
        addr_d  = ADDR_WIDTH'(1);
        state_d = (k_q > LEN_WIDTH'(1)) ? STREAM : CAPTURE;
      end
      STREAM: begin
        rd_en   = 1'b1;
        rd_addr = addr_q;
        addr_d  = addr_q + ADDR_WIDTH'(1);
        if (LEN_WIDTH'(addr_q) == k_q - LEN_WIDTH'(1)) state_d = CAPTURE;
      end
      CAPTURE: begin
        // A still-valid beat means the PE has not absorbed the last product yet.
        if (!valid_q) begin
          res_d       = acc_i;
          res_valid_d = 1'b1;
          state_d     = RESULT;
        end
      end
      RESULT: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = rd_en;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      k_q         <= '0;
      addr_q      <= '0;
      valid_q     <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      addr_q      <= addr_d;
      valid_q     <= valid_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign rd_en_o     = rd_en;
  assign rd_addr_o   = rd_addr;
  assign acc_clr_o   = acc_clr;
  assign a_valid_o   = valid_q;
  assign b_valid_o   = valid_q;
  assign a_o         = valid_q ? a_rdata_i : '0;
  assign b_o         = valid_q ? b_rdata_i : '0;
  assign res_o       = res_q;
  assign res_valid_o = res_valid_q;

`ifdef MAC_PE_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (busy_o && (perf_q != '1)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perf_q <= '0;
    else         perf_q <= perf_d;
  end

  assign perf_busy_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_mac_pe_sequencer.sv
// Bench for mac_pe_sequencer driving a real mac_pe from two 1-cycle SRAM models.
module tb_mac_pe_sequencer;

  localparam int DW = 16;
  localparam int KM = 16;
  localparam int AW = 4;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] k_len;
  logic          busy, rd_en, a_valid, b_valid, acc_clr, res_valid, res_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] a_rdata, b_rdata, a_o, b_o, acc, res;
`ifdef MAC_PE_SEQ_PERF_EN
  logic [31:0]   perf;
`endif

  logic [DW-1:0] mem_a [KM];
  logic [DW-1:0] mem_b [KM];

  int n_cmp = 0;
  int n_err = 0;
  int beats, rds, clrs, max_addr;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      a_rdata <= mem_a[rd_addr];
      b_rdata <= mem_b[rd_addr];
    end
  end

  mac_pe_sequencer #(.DATA_WIDTH(DW), .K_MAX(KM)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .k_len_i(k_len),
    .busy_o(busy), .rd_en_o(rd_en), .rd_addr_o(rd_addr),
    .a_rdata_i(a_rdata), .b_rdata_i(b_rdata), .a_o(a_o), .b_o(b_o),
    .a_valid_o(a_valid), .b_valid_o(b_valid), .acc_clr_o(acc_clr),
    .acc_i(acc), .res_o(res), .res_valid_o(res_valid), .res_ready_i(res_ready)
`ifdef MAC_PE_SEQ_PERF_EN
    , .perf_busy_cycles_o(perf)
`endif
  );

  mac_pe #(.DATA_WIDTH(DW)) u_pe (
    .clk_i(clk), .rst_ni(rst_n), .acc_clr_i(acc_clr),
    .a_valid_i(a_valid), .b_valid_i(b_valid), .a_i(a_o), .b_i(b_o), .acc_o(acc)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a run is described only by its start-relative cycle index t.
  bit            m_active = 1'b0;
  int            m_t, m_k;
  logic [DW-1:0] m_a [KM];
  logic [DW-1:0] m_b [KM];
  logic [DW-1:0] m_dot, m_prev;

  function automatic int sat_k(input logic [LW-1:0] kl);
    return (int'(kl) > KM) ? KM : int'(kl);
  endfunction

  function automatic logic [DW-1:0] dot_of(input int k);
    logic [31:0] s = 0;
    for (int i = 0; i < k; i++) s = s + 32'(mem_a[i]) * 32'(mem_b[i]);
    return s[DW-1:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_prev   <= '0;
    end else if (m_active) begin
      if (m_t >= m_k + 3 && res_ready) begin
        m_active <= 1'b0;
        m_prev   <= m_dot;
      end else begin
        m_t <= m_t + 1;
      end
    end else if (start) begin
      m_active <= 1'b1;
      m_t      <= 1;
      m_k      <= sat_k(k_len);
      m_dot    <= dot_of(sat_k(k_len));
      m_a      <= mem_a;
      m_b      <= mem_b;
    end
  end

  always @(negedge clk) begin
    logic          e_rd, e_val, e_rv;
    logic [DW-1:0] e_a, e_b;
    int            t;
    t     = m_t;
    e_rd  = m_active && t >= 1 && t <= m_k;
    e_val = m_active && t >= 2 && t <= m_k + 1;
    e_rv  = m_active && t >= m_k + 3;
    e_a   = '0;
    e_b   = '0;
    if (e_val) begin
      e_a = m_a[t-2];
      e_b = m_b[t-2];
    end
    chk("busy", busy, m_active);
    chk("acc_clr", acc_clr, m_active && t == 1);
    chk("rd_en", rd_en, e_rd);
    chk("rd_addr", rd_addr, e_rd ? 64'(t - 1) : 64'd0);
    chk("a_valid", a_valid, e_val);
    chk("b_valid", b_valid, e_val);
    chk("a_o", a_o, e_a);
    chk("b_o", b_o, e_b);
    chk("res_valid", res_valid, e_rv);
    chk("res", res, e_rv ? m_dot : m_prev);
    if (a_valid) beats++;
    if (acc_clr) clrs++;
    if (rd_en) begin
      rds++;
      if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_run(input int k);
    beats = 0; rds = 0; clrs = 0; max_addr = 0;
    k_len = LW'(k);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 1;
    while (!res_valid && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_rd_en"}, rd_en, 0);
    chk({nm, "_rd_addr"}, rd_addr, 0);
    chk({nm, "_valid"}, {a_valid, b_valid}, 0);
    chk({nm, "_ab"}, {a_o, b_o}, 0);
    chk({nm, "_clr"}, acc_clr, 0);
    chk({nm, "_res"}, res, 0);
    chk({nm, "_res_valid"}, res_valid, 0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; start = 1'b0; k_len = '0; res_ready = 1'b1;
    for (int i = 0; i < KM; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    #3;
    chk_all_zero("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      mem_a[i] = DW'(i + 1);
      mem_b[i] = DW'(i + 5);
    end
    start_run(4);
    wait_res(lat);
    chk("k4_latency", lat, 7);
    chk("k4_res", res, 70);
    tick();
    chk("k4_beats", beats, 4);
    chk("k4_clears", clrs, 1);
    chk("k4_idle", busy, 0);

    mem_a[0] = 16'd256; mem_b[0] = 16'd256;
    start_run(1);
    wait_res(lat);
    chk("wrap_latency", lat, 4);
    chk("wrap_res", res, 0);
    tick();

    mem_a[0] = 16'd100; mem_b[0] = 16'd100;
    start_run(1);
    wait_res(lat);
    chk("k1_latency", lat, 4);
    chk("k1_res", res, 10000);
    tick();

    start_run(0);
    wait_res(lat);
    chk("k0_latency", lat, 3);
    chk("k0_res", res, 0);
    tick();
    chk("k0_reads", rds, 0);
    chk("k0_beats", beats, 0);

    for (int i = 0; i < 4; i++) begin
      mem_a[i] = DW'(i + 1);
      mem_b[i] = DW'(i + 5);
    end
    res_ready = 1'b0;
    start_run(4);
    wait_res(lat);
    chk("stall_latency", lat, 7);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      k_len = 5'd3;
      chk("stall_res", res, 70);
      chk("stall_res_valid", res_valid, 1);
      tick();
    end
    res_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("stall_idle", busy, 0);
    tick();
    chk("stall_still_idle", busy, 0);

    for (int i = 0; i < KM; i++) begin mem_a[i] = '1; mem_b[i] = '1; end
    start_run(16);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    mem_a[0] = 3; mem_a[1] = 3; mem_b[0] = 2; mem_b[1] = 2;
    start_run(2);
    wait_res(lat);
    chk("post_rst_latency", lat, 5);
    chk("post_rst_res", res, 12);
    tick();

    for (int i = 0; i < KM; i++) begin mem_a[i] = DW'($urandom); mem_b[i] = DW'($urandom); end
    start_run(31);
    wait_res(lat);
    chk("sat_latency", lat, 19);
    tick();
    chk("sat_beats", beats, 16);
    chk("sat_max_addr", max_addr, 15);

    for (int c = 0; c < 3000; c++) begin
      if (!m_active) begin
        mem_a[$urandom_range(KM-1)] = ($urandom % 4 == 0) ? DW'($urandom) : DW'($urandom % 64);
        mem_b[$urandom_range(KM-1)] = ($urandom % 4 == 0) ? DW'($urandom) : DW'($urandom % 64);
      end
      start     = ($urandom % 3 == 0);
      k_len     = LW'($urandom % 32);
      res_ready = ($urandom % 2 == 0);
      if ($urandom % 400 == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    res_ready = 1'b1;
    repeat (30) tick();
    chk("final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
